// File: rtl/multi_pulse_stretcher_if.sv
// Channel bundle for the pulse stretcher: raw inputs and shared controls in, pulses and flags out.
interface multi_pulse_stretcher_if #(
   parameter int CH    = 4,
   parameter int LEN_W = 8
);
   logic [CH-1:0]    Pin;
   logic [LEN_W-1:0] Len;
   logic             Retrig;
   logic             MissClr;
   logic [CH-1:0]    Pout;
   logic [CH-1:0]    Done;
   logic [CH-1:0]    Miss;

   modport master (
      output Pin, Len, Retrig, MissClr,
      input  Pout, Done, Miss
   );

   modport slave (
      input  Pin, Len, Retrig, MissClr,
      output Pout, Done, Miss
   );
endinterface

// File: rtl/multi_pulse_stretcher.sv
// N-channel edge-triggered pulse stretcher with programmable length, retrigger/ignore, done strobe, sticky miss.
// Pout rises one cycle after the triggering edge; no backpressure, every channel runs independently each cycle.
module multi_pulse_stretcher #(
   parameter int CH    = 4,
   parameter int LEN_W = 8,
   parameter int EDGE  = 0
) (
   input logic                  Clk,
   input logic                  Rst,
   multi_pulse_stretcher_if.slave bus
);

   typedef enum logic {IDLE, ACTIVE} state_e;

   state_e           state_q [CH];
   state_e           state_d [CH];
   logic [LEN_W-1:0] cnt_q   [CH];
   logic [LEN_W-1:0] cnt_d   [CH];
   logic [CH-1:0]    pout_q, pout_d;
   logic [CH-1:0]    done_q, done_d;
   logic [CH-1:0]    miss_q, miss_d;
   logic [CH-1:0]    pin_dly_q;
   logic [CH-1:0]    trig;
   logic [LEN_W-1:0] len_eff;
   logic [LEN_W-1:0] load_val;

   always_comb begin
      len_eff  = (bus.Len == '0) ? LEN_W'(1) : bus.Len;
      load_val = len_eff - LEN_W'(1);
      if (EDGE == 0) begin
         trig = bus.Pin & ~pin_dly_q;
      end else if (EDGE == 1) begin
         trig = ~bus.Pin & pin_dly_q;
      end else begin
         trig = bus.Pin ^ pin_dly_q;
      end
   end

   always_comb begin
      pout_d = '0;
      done_d = '0;
      miss_d = miss_q & {CH{~bus.MissClr}};
      for (int i = 0; i < CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            IDLE: begin
               if (trig[i]) begin
                  state_d[i] = ACTIVE;
                  cnt_d[i]   = load_val;
                  pout_d[i]  = 1'b1;
               end
            end
            ACTIVE: begin
               if (trig[i] && bus.Retrig) begin
                  cnt_d[i]  = load_val;
                  pout_d[i] = 1'b1;
               end else begin
                  // An ignored trigger only flags; set beats a same-cycle clear.
                  if (trig[i]) begin
                     miss_d[i] = 1'b1;
                  end
                  if (cnt_q[i] == '0) begin
                     state_d[i] = IDLE;
                     done_d[i]  = 1'b1;
                  end else begin
                     cnt_d[i]  = cnt_q[i] - LEN_W'(1);
                     pout_d[i] = 1'b1;
                  end
               end
            end
            default: begin
               state_d[i] = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      // Edge history follows the input through reset so a held-high input does not fire on release.
      pin_dly_q <= bus.Pin;
      if (Rst) begin
         pout_q <= '0;
         done_q <= '0;
         miss_q <= '0;
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         pout_q <= pout_d;
         done_q <= done_d;
         miss_q <= miss_d;
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   assign bus.Pout = pout_q;
   assign bus.Done = done_q;
   assign bus.Miss = miss_q;

endmodule

// File: tb/tb_multi_pulse_stretcher.sv
// Scoreboard bench: three stretchers (rising, falling, both edges) share stimulus; a remaining-cycles model predicts outputs.
module tb_multi_pulse_stretcher;
   localparam int CH    = 4;
   localparam int LEN_W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [CH-1:0]    pin;
   logic [LEN_W-1:0] len;
   logic             retrig;
   logic             missclr;

   multi_pulse_stretcher_if #(.CH(CH), .LEN_W(LEN_W)) bus0 ();
   multi_pulse_stretcher_if #(.CH(CH), .LEN_W(LEN_W)) bus1 ();
   multi_pulse_stretcher_if #(.CH(CH), .LEN_W(LEN_W)) bus2 ();

   assign bus0.Pin = pin;  assign bus0.Len = len;  assign bus0.Retrig = retrig;  assign bus0.MissClr = missclr;
   assign bus1.Pin = pin;  assign bus1.Len = len;  assign bus1.Retrig = retrig;  assign bus1.MissClr = missclr;
   assign bus2.Pin = pin;  assign bus2.Len = len;  assign bus2.Retrig = retrig;  assign bus2.MissClr = missclr;

   multi_pulse_stretcher #(.CH(CH), .LEN_W(LEN_W), .EDGE(0)) u_dut0 (.Clk(clk), .Rst(rst), .bus(bus0));
   multi_pulse_stretcher #(.CH(CH), .LEN_W(LEN_W), .EDGE(1)) u_dut1 (.Clk(clk), .Rst(rst), .bus(bus1));
   multi_pulse_stretcher #(.CH(CH), .LEN_W(LEN_W), .EDGE(2)) u_dut2 (.Clk(clk), .Rst(rst), .bus(bus2));

   logic [2:0][CH-1:0] act_pout, act_done, act_miss;
   assign act_pout[0] = bus0.Pout;  assign act_done[0] = bus0.Done;  assign act_miss[0] = bus0.Miss;
   assign act_pout[1] = bus1.Pout;  assign act_done[1] = bus1.Done;  assign act_miss[1] = bus1.Miss;
   assign act_pout[2] = bus2.Pout;  assign act_done[2] = bus2.Done;  assign act_miss[2] = bus2.Miss;

   typedef struct {
      int                 tag;
      logic [2:0][CH-1:0] pout;
      logic [2:0][CH-1:0] done;
      logic [2:0][CH-1:0] miss;
   } exp_t;

   exp_t exp_q [$];
   int   checks   = 0;
   int   errors   = 0;
   int   edge_cnt = 0;
   int   tag_next = 1;

   // Model state: cycles of high output still owed, previous input level, sticky miss.
   int m_rem  [3][CH];
   bit m_prev [3][CH];
   bit m_miss [3][CH];

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic tick();
      exp_t e;
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < CH; i++) begin
            bit rise, fall, trg, was_on;
            int le;
            rise   = pin[i] && !m_prev[d][i];
            fall   = !pin[i] && m_prev[d][i];
            trg    = (d == 0) ? rise : (d == 1) ? fall : (rise || fall);
            le     = (len == 0) ? 1 : int'(len);
            was_on = (m_rem[d][i] > 0);
            if (rst) begin
               m_rem[d][i]  = 0;
               m_miss[d][i] = 1'b0;
               e.done[d][i] = 1'b0;
            end else begin
               if (trg && (!was_on || retrig)) m_rem[d][i] = le;
               else if (m_rem[d][i] > 0)      m_rem[d][i] = m_rem[d][i] - 1;
               m_miss[d][i] = (trg && was_on && !retrig) || (m_miss[d][i] && !missclr);
               e.done[d][i] = was_on && (m_rem[d][i] == 0);
            end
            m_prev[d][i] = pin[i];
            e.pout[d][i] = (m_rem[d][i] > 0);
            e.miss[d][i] = m_miss[d][i];
         end
      end
      e.tag = tag_next;
      tag_next++;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].tag <= edge_cnt) begin
            e = exp_q.pop_front();
            for (int d = 0; d < 3; d++) begin
               checks++;
               if (act_pout[d] !== e.pout[d] || act_done[d] !== e.done[d] || act_miss[d] !== e.miss[d]) begin
                  errors++;
                  $display("FAIL edge_mode%0d cycle %0d: pout=%b done=%b miss=%b expected pout=%b done=%b miss=%b",
                           d, e.tag, act_pout[d], act_done[d], act_miss[d], e.pout[d], e.done[d], e.miss[d]);
               end
            end
         end
      end
   end

   initial begin : stimulus
      rst = 1'b1; pin = 4'b0100; len = 8'd5; retrig = 1'b0; missclr = 1'b0;
      idle(3);
      rst = 1'b0;
      idle(6);
      pin = 4'b0000;
      idle(6);

      // Single 5-cycle pulse on channel 0.
      pin[0] = 1'b1; idle(2); pin[0] = 1'b0; idle(10);

      // Retrigger extends channel 1 to 8 cycles.
      retrig = 1'b1;
      pin[1] = 1'b1; idle(1); pin[1] = 1'b0; idle(2); pin[1] = 1'b1; idle(1); pin[1] = 1'b0; idle(12);

      // Ignored retrigger flags miss; clear and new miss on the same edge keeps it set.
      retrig = 1'b0;
      pin[1] = 1'b1; idle(1); pin[1] = 1'b0; idle(2); pin[1] = 1'b1; idle(1); pin[1] = 1'b0; idle(8);
      missclr = 1'b1; idle(1); missclr = 1'b0; idle(2);
      pin[1] = 1'b1; idle(1); pin[1] = 1'b0; idle(1);
      pin[1] = 1'b1; missclr = 1'b1; idle(1); pin[1] = 1'b0; missclr = 1'b0; idle(8);

      // Retrigger landing on the final active cycle, and trigger on the done cycle.
      retrig = 1'b1; len = 8'd3;
      pin[0] = 1'b1; idle(1); pin[0] = 1'b0; idle(1); pin[0] = 1'b1; idle(1); pin[0] = 1'b0; idle(3);
      retrig = 1'b0;
      pin[0] = 1'b1; idle(1); pin[0] = 1'b0; idle(2); pin[0] = 1'b1; idle(1); pin[0] = 1'b0; idle(6);

      // Length extremes and a mid-pulse length change.
      len = 8'd0;   pin[2] = 1'b1; idle(1); pin[2] = 1'b0; idle(4);
      len = 8'd255; pin[2] = 1'b1; idle(1); pin[2] = 1'b0; idle(260);
      len = 8'd10;  pin[0] = 1'b1; idle(1); len = 8'd2; pin[0] = 1'b0; idle(14);

      // Reset in the middle of a pulse.
      len = 8'd20; pin[3] = 1'b1; idle(1); pin[3] = 1'b0; idle(4);
      rst = 1'b1; idle(2); rst = 1'b0; idle(4);

      // Both-edge channel: high then low 20 cycles later.
      len = 8'd3; pin[3] = 1'b1; idle(20); pin[3] = 1'b0; idle(8);

      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < CH; i++) if ($urandom_range(0, 7) == 0) pin[i] = ~pin[i];
         if ($urandom_range(0, 19) == 0) len = LEN_W'($urandom_range(0, 12));
         if ($urandom_range(0, 29) == 0) retrig = ~retrig;
         missclr = ($urandom_range(0, 14) == 0);
         rst     = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst = 1'b0; missclr = 1'b0;
      idle(2);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
